// File: rtl/bcd5_to_bin16.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift-and-correct
// iteration per clock, with saturating overflow and invalid-digit detection.
module bcd5_to_bin16 #(
  parameter int N_DIG = 5,
  parameter int OUT_W = 16,
  parameter int ITER  = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*N_DIG-1:0] digits,
  output logic               busy,
  output logic               done,
  output logic [OUT_W-1:0]   bin,
  output logic               overflow,
  output logic               invalid,
  output logic               dbg_state
);

  // Handshake: start is sampled only while idle (busy=0); done is a one-cycle
  // pulse and bin/overflow/invalid are valid from that cycle until the next done.

  localparam int BCD_W = 4 * N_DIG;
  localparam int SR_W  = BCD_W + ITER;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_shift;
  logic [SR_W-1:0]  sr_next;
  logic [3:0]       nib;
  logic             digit_bad;
  logic             last_iter;

  always_comb begin
    digit_bad = 1'b0;
    for (int k = 0; k < N_DIG; k++) begin
      if (digits[4*k +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // After the right shift, any BCD nibble >= 8 has absorbed a decimal carry
  // worth 5 in the lower digit; subtracting 3 restores a valid BCD digit.
  always_comb begin
    sr_shift = sr >> 1;
    sr_next  = sr_shift;
    nib      = '0;
    for (int k = 0; k < N_DIG; k++) begin
      nib = sr_shift[ITER + 4*k +: 4];
      if (nib >= 4'd8) sr_next[ITER + 4*k +: 4] = nib - 4'd3;
    end
  end

  assign last_iter = (cnt == CNT_W'(ITER - 1));
  assign dbg_state = (state == CONV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bin      <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr <= {digits, {ITER{1'b0}}};
            if (digit_bad) begin
              done     <= 1'b1;
              invalid  <= 1'b1;
              bin      <= '0;
              overflow <= 1'b0;
            end else begin
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CONV;
            end
          end
        end
        CONV: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            invalid <= 1'b0;
            // The binary value now sits in the low ITER bits; anything above
            // OUT_W means the decimal input does not fit the output word.
            if (|sr_next[ITER-1:OUT_W]) begin
              bin      <= '1;
              overflow <= 1'b1;
            end else begin
              bin      <= sr_next[OUT_W-1:0];
              overflow <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd5_to_bin16.sv
// Bench for bcd5_to_bin16: table vectors, hand-written handshake/reset sequences
// and random digits checked against a decimal-arithmetic reference model.
module tb_bcd5_to_bin16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] digits;
  logic        busy;
  logic        done;
  logic [15:0] bin;
  logic        overflow;
  logic        invalid;
  logic        dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_bin;

  typedef struct {
    logic [19:0] d;
    logic [15:0] b;
    logic        ov;
    logic        inv;
  } vec_t;

  vec_t tbl[10];

  bcd5_to_bin16 dut (
    .clk(clk), .rst(rst), .start(start), .digits(digits),
    .busy(busy), .done(done), .bin(bin), .overflow(overflow),
    .invalid(invalid), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reference: evaluate the decimal number with plain arithmetic.
  function automatic void model(input logic [19:0] d, output logic [15:0] b,
                                output logic ov, output logic inv);
    int v;
    int dg;
    v   = 0;
    inv = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      dg = int'(d[4*i +: 4]);
      if (dg > 9) inv = 1'b1;
      v = v * 10 + dg;
    end
    if (inv) begin
      b = 16'h0000; ov = 1'b0;
    end else if (v > 65535) begin
      b = 16'hFFFF; ov = 1'b1;
    end else begin
      b = 16'(v); ov = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [19:0] d);
    start  = 1'b1;
    digits = d;
    @(posedge clk); #1;
    start  = 1'b0;
    digits = 20'($urandom);
  endtask

  // Counts edges until done; also notes whether busy dropped or bin moved early.
  task automatic wait_done(output int lat, output bit held);
    lat  = 0;
    held = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy || bin !== last_bin) held = 1'b0;
    end
  endtask

  task automatic run_one(input logic [19:0] d, input logic [15:0] eb, input logic eo,
                         input logic ei, input string tag);
    int lat;
    bit held;
    launch(d);
    if (ei) begin
      check({tag, " inv done"}, done, 1);
      check({tag, " inv flag"}, invalid, 1);
      check({tag, " inv bin"}, bin, 0);
      check({tag, " inv ovf"}, overflow, 0);
      check({tag, " inv busy"}, busy, 0);
      @(posedge clk); #1;
      check({tag, " inv done clr"}, done, 0);
    end else begin
      check({tag, " busy"}, busy, 1);
      check({tag, " no early done"}, done, 0);
      wait_done(lat, held);
      check({tag, " latency"}, lat, 17);
      check({tag, " hold"}, held, 1);
      check({tag, " bin"}, bin, eb);
      check({tag, " ovf"}, overflow, eo);
      check({tag, " inv"}, invalid, 0);
      check({tag, " busy clr"}, busy, 0);
    end
    last_bin = eb;
  endtask

  initial begin
    int          lat;
    bit          held;
    logic [19:0] rd;
    logic [15:0] eb;
    logic        eo;
    logic        ei;

    tbl[0] = '{20'h12345, 16'h3039, 1'b0, 1'b0};
    tbl[1] = '{20'h65535, 16'hFFFF, 1'b0, 1'b0};
    tbl[2] = '{20'h70000, 16'hFFFF, 1'b1, 1'b0};
    tbl[3] = '{20'h99999, 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{20'h0A012, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{20'h65536, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{20'h10000, 16'h2710, 1'b0, 1'b0};
    tbl[7] = '{20'h00001, 16'h0001, 1'b0, 1'b0};
    tbl[8] = '{20'hF0000, 16'h0000, 1'b0, 1'b1};
    tbl[9] = '{20'h00999, 16'h03E7, 1'b0, 1'b0};

    // Clock/reset
    rst = 1'b1; start = 1'b0; digits = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst bin", bin, 0);
    check("rst ovf", overflow, 0);
    check("rst inv", invalid, 0);
    rst = 1'b0;
    last_bin = 16'h0000;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_one(tbl[i].d, tbl[i].b, tbl[i].ov, tbl[i].inv, $sformatf("tbl%0d", i));

    // Start during conversion is ignored; start in the done cycle is accepted.
    launch(20'h00203);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; digits = 20'h00999;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, held);
    check("ign latency", lat, 12);
    check("ign hold", held, 1);
    check("ign bin", bin, 16'h00CB);
    last_bin = 16'h00CB;
    run_one(20'h00004, 16'h0004, 1'b0, 1'b0, "b2b");

    // start held high: a new conversion every time the block goes idle.
    start = 1'b1; digits = 20'h00042;
    wait_done(lat, held);
    check("hold1 latency", lat, 18);
    check("hold1 bin", bin, 16'h002A);
    last_bin = 16'h002A;
    wait_done(lat, held);
    check("hold2 latency", lat, 18);
    check("hold2 bin", bin, 16'h002A);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold idle", busy, 0);

    // Reset mid-conversion aborts without done.
    launch(20'h00012);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst bin", bin, 0);
    check("mid rst done", done, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("mid rst no done", done, 0);
    rst = 1'b0;
    last_bin = 16'h0000;
    @(posedge clk); #1;
    run_one(20'h00012, 16'h000C, 1'b0, 1'b0, "post rst");

    // Zero is a full-latency conversion; bin holds 12 until its done.
    run_one(20'h00000, 16'h0000, 1'b0, 1'b0, "zero");

    // Random digits, mostly valid with occasional out-of-range nibbles.
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 7) == 0) rd[4*i +: 4] = 4'($urandom_range(10, 15));
        else                           rd[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      model(rd, eb, eo, ei);
      run_one(rd, eb, eo, ei, $sformatf("rnd %05h", rd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
